// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        PLLRST,
        WAITLOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL
    } seq_state_e;

    localparam int DEF_NUM_DOMAINS      = 8;
    localparam int DEF_PLL_RST_CYC      = 16;
    localparam int DEF_LOCK_TIMEOUT_CYC = 50000;
    localparam int DEF_LOCK_STABLE_CYC  = 1024;
    localparam int DEF_STAGGER_CYC      = 64;
    localparam int DEF_MAX_RETRY        = 3;

    // Largest of the cycle counts that share the single phase counter.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and domain-reset signals of the sequencer, grouped as one bundle.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level-valued.
interface pll_reset_sequencer_if
    import pll_reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS
);
    logic                   pll_locked;
    logic                   sw_reset_req;
    logic                   pll_rst;
    logic [NUM_DOMAINS-1:0] domain_rstn;
    logic                   all_ready;
    logic                   pll_fail;
    logic [1:0]             retry_cnt;

    // Sequencer side.
    modport master (
        input  pll_locked, sw_reset_req,
        output pll_rst, domain_rstn, all_ready, pll_fail, retry_cnt
    );

    // PLL / clock-domain side.
    modport slave (
        output pll_locked, sw_reset_req,
        input  pll_rst, domain_rstn, all_ready, pll_fail, retry_cnt
    );
endinterface

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous level input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
module sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);
    logic meta;

    // Two-stage capture; both stages clear to 0 on reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor with staggered per-domain reset release and lock retry.
// Latency: lock seen 2 cycles after pll_locked; all outputs registered (1 cycle after decision).
// Backpressure: none; sw_reset_req is a one-cycle pulse acted on only in RELEASE/RUN/FAIL.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS      = DEF_NUM_DOMAINS,
    parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
    parameter int STAGGER_CYC      = DEF_STAGGER_CYC,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic                  clk,
    input  logic                  rstn,
    pll_reset_sequencer_if.master bus
);
    localparam int CNT_MAX = max4(LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC, PLL_RST_CYC, STAGGER_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DOMAINS + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);
    localparam logic [NUM_DOMAINS-1:0] DOM_BIT0 = {{(NUM_DOMAINS-1){1'b0}}, 1'b1};

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [1:0]             retry_q, retry_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    logic                   fail_q, fail_d;
    logic                   lk;
    logic [1:0]             retry_inc;

    sync_2ff u_lock_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (bus.pll_locked),
        .q    (lk)
    );

    assign retry_inc = retry_q + 2'd1;

    // State and output registers; reset puts the PLL back into reset with every domain held.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= PLLRST;
            cnt_q     <= '0;
            idx_q     <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            dom_q     <= dom_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // Next-state and next-output decisions; the phase counter restarts on every state change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        pll_rst_d = pll_rst_q;
        dom_d     = dom_q;
        ready_d   = ready_q;
        fail_d    = fail_q;
        case (state_q)
            PLLRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d   = WAITLOCK;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAITLOCK: begin
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d   = retry_inc;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    if (retry_inc == RETRY_LIMIT) begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = PLLRST;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                // Any dropout sends us back to wait for lock with a fresh timeout.
                if (!lk) begin
                    state_d = WAITLOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE, RUN: begin
                // Lock loss outranks a soft reset: the PLL itself must be restarted.
                if (!lk) begin
                    state_d   = PLLRST;
                    cnt_d     = '0;
                    idx_d     = '0;
                    retry_d   = '0;
                    pll_rst_d = 1'b1;
                    dom_d     = '0;
                    ready_d   = 1'b0;
                end else if (bus.sw_reset_req) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '0;
                    ready_d = 1'b0;
                end else if (state_q == RELEASE) begin
                    if (cnt_q == STAGGER_LAST) begin
                        cnt_d = '0;
                        dom_d = dom_q | (DOM_BIT0 << idx_q);
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                            retry_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            FAIL: begin
                // Parked with the PLL in reset until software asks for a new attempt.
                if (bus.sw_reset_req) begin
                    state_d = PLLRST;
                    cnt_d   = '0;
                    retry_d = '0;
                    fail_d  = 1'b0;
                end
            end
            default: begin
                state_d   = PLLRST;
                cnt_d     = '0;
                pll_rst_d = 1'b1;
                dom_d     = '0;
                ready_d   = 1'b0;
            end
        endcase
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.domain_rstn = dom_q;
    assign bus.all_ready   = ready_q;
    assign bus.pll_fail    = fail_q;
    assign bus.retry_cnt   = retry_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed vector table, boot-latency sequence, random soak vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_reset_sequencer;
    localparam int P_N     = 8;
    localparam int P_RST   = 4;
    localparam int P_TMO   = 32;
    localparam int P_STB   = 8;
    localparam int P_STG   = 2;
    localparam int P_RETRY = 2;
    localparam int NVEC    = 33;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_pass;
    int   cyc;

    pll_reset_sequencer_if #(.NUM_DOMAINS(P_N)) bus ();

    pll_reset_sequencer #(
        .NUM_DOMAINS      (P_N),
        .PLL_RST_CYC      (P_RST),
        .LOCK_TIMEOUT_CYC (P_TMO),
        .LOCK_STABLE_CYC  (P_STB),
        .STAGGER_CYC      (P_STG),
        .MAX_RETRY        (P_RETRY)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase plus cycles elapsed in that phase.
    typedef enum {M_RST, M_WAIT, M_STAB, M_REL, M_RUN, M_FAIL} ph_t;
    ph_t  m_ph;
    int   m_t;
    int   m_retry;
    logic m_s1, m_s2;

    task automatic model_step(input logic r, input logic l, input logic s);
        logic lk;
        if (!r) begin
            m_ph = M_RST; m_t = 0; m_retry = 0; m_s1 = 1'b0; m_s2 = 1'b0;
        end else begin
            lk = m_s2; m_s2 = m_s1; m_s1 = l;
            case (m_ph)
                M_RST: begin
                    m_t++;
                    if (m_t == P_RST) begin m_ph = M_WAIT; m_t = 0; end
                end
                M_WAIT: begin
                    if (lk) begin
                        m_ph = M_STAB; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t == P_TMO) begin
                            m_retry++;
                            m_t = 0;
                            m_ph = (m_retry == P_RETRY) ? M_FAIL : M_RST;
                        end
                    end
                end
                M_STAB: begin
                    if (!lk) begin
                        m_ph = M_WAIT; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t == P_STB) begin m_ph = M_REL; m_t = 0; end
                    end
                end
                M_REL, M_RUN: begin
                    if (!lk) begin
                        m_ph = M_RST; m_t = 0; m_retry = 0;
                    end else if (s) begin
                        m_ph = M_REL; m_t = 0;
                    end else if (m_ph == M_REL) begin
                        m_t++;
                        if (m_t == P_N * P_STG) begin m_ph = M_RUN; m_retry = 0; end
                    end
                end
                M_FAIL: begin
                    if (s) begin m_ph = M_RST; m_t = 0; m_retry = 0; end
                end
                default: m_ph = M_RST;
            endcase
        end
    endtask

    // Packed view {pll_rst, pll_fail, all_ready, retry_cnt, domain_rstn}.
    function automatic logic [12:0] model_vec();
        logic [7:0] dom;
        if (m_ph == M_RUN)      dom = 8'hFF;
        else if (m_ph == M_REL) dom = 8'((1 << (m_t / P_STG)) - 1);
        else                    dom = 8'h00;
        return {(m_ph == M_RST || m_ph == M_FAIL), (m_ph == M_FAIL), (m_ph == M_RUN),
                2'(m_retry), dom};
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus.pll_rst, bus.pll_fail, bus.all_ready, bus.retry_cnt, bus.domain_rstn};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge.
    task automatic tick(input logic r, input logic l, input logic s);
        logic [7:0] d;
        rstn             = r;
        bus.pll_locked   = l;
        bus.sw_reset_req = s;
        @(posedge clk);
        model_step(r, l, s);
        @(negedge clk);
        cyc++;
        check("model", {3'b0, dut_vec()}, {3'b0, model_vec()});
        d = bus.domain_rstn;
        check("order", {8'h00, d & (d + 8'd1)}, 16'h0000);
    endtask

    typedef struct {
        logic       rstn;
        logic       locked;
        logic       sw;
        int         n;
        logic       pll_rst;
        logic       pll_fail;
        logic       all_ready;
        logic [1:0] retry;
        logic [7:0] dom;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic l, input logic s, input int n,
                                input logic pr, input logic pf, input logic ar,
                                input logic [1:0] rc, input logic [7:0] d);
        vec_t v;
        v.rstn = r; v.locked = l; v.sw = s; v.n = n;
        v.pll_rst = pr; v.pll_fail = pf; v.all_ready = ar; v.retry = rc; v.dom = d;
        return v;
    endfunction

    vec_t vecs [NVEC];

    initial begin
        int   lat;
        logic l, s, r;
        int   len;
        n_checks = 0; n_pass = 0; cyc = 0;
        rstn = 1'b0; bus.pll_locked = 1'b0; bus.sw_reset_req = 1'b0;

        //              rstn lk sw  n   prst fail rdy retry dom
        // reset values
        vecs[0]  = mk(0, 0, 0, 2,  1, 0, 0, 2'd0, 8'h00);
        // clean boot: pll_rst 4 cycles, lock applied 5 cycles after it falls
        vecs[1]  = mk(1, 0, 0, 3,  1, 0, 0, 2'd0, 8'h00);
        vecs[2]  = mk(1, 0, 0, 1,  0, 0, 0, 2'd0, 8'h00);
        vecs[3]  = mk(1, 0, 0, 4,  0, 0, 0, 2'd0, 8'h00);
        vecs[4]  = mk(1, 1, 0, 14, 0, 0, 0, 2'd0, 8'h01);
        vecs[5]  = mk(1, 1, 0, 2,  0, 0, 0, 2'd0, 8'h03);
        vecs[6]  = mk(1, 1, 0, 10, 0, 0, 0, 2'd0, 8'h7F);
        vecs[7]  = mk(1, 1, 0, 1,  0, 0, 1, 2'd0, 8'hFF);
        // lock loss in RUN: visible on the third edge after the drop
        vecs[8]  = mk(1, 1, 0, 3,  0, 0, 1, 2'd0, 8'hFF);
        vecs[9]  = mk(1, 0, 0, 2,  0, 0, 1, 2'd0, 8'hFF);
        vecs[10] = mk(1, 0, 0, 1,  1, 0, 0, 2'd0, 8'h00);
        // never locks: two 32-cycle timeouts then FAIL; lock ignored in FAIL
        vecs[11] = mk(1, 0, 0, 4,  0, 0, 0, 2'd0, 8'h00);
        vecs[12] = mk(1, 0, 0, 31, 0, 0, 0, 2'd0, 8'h00);
        vecs[13] = mk(1, 0, 0, 1,  1, 0, 0, 2'd1, 8'h00);
        vecs[14] = mk(1, 0, 0, 4,  0, 0, 0, 2'd1, 8'h00);
        vecs[15] = mk(1, 0, 0, 31, 0, 0, 0, 2'd1, 8'h00);
        vecs[16] = mk(1, 0, 0, 1,  1, 1, 0, 2'd2, 8'h00);
        vecs[17] = mk(1, 1, 0, 6,  1, 1, 0, 2'd2, 8'h00);
        vecs[18] = mk(1, 0, 1, 1,  1, 0, 0, 2'd0, 8'h00);
        // glitchy lock: 5 high, 1 low, then steady; release restarts the stable count
        vecs[19] = mk(1, 0, 0, 4,  0, 0, 0, 2'd0, 8'h00);
        vecs[20] = mk(1, 1, 0, 5,  0, 0, 0, 2'd0, 8'h00);
        vecs[21] = mk(1, 0, 0, 1,  0, 0, 0, 2'd0, 8'h00);
        vecs[22] = mk(1, 1, 0, 10, 0, 0, 0, 2'd0, 8'h00);
        vecs[23] = mk(1, 1, 0, 3,  0, 0, 0, 2'd0, 8'h01);
        vecs[24] = mk(1, 1, 0, 14, 0, 0, 1, 2'd0, 8'hFF);
        // soft reset in RUN, then soft reset + lock loss together at 0x07
        vecs[25] = mk(1, 1, 1, 1,  0, 0, 0, 2'd0, 8'h00);
        vecs[26] = mk(1, 1, 0, 4,  0, 0, 0, 2'd0, 8'h03);
        vecs[27] = mk(1, 0, 0, 2,  0, 0, 0, 2'd0, 8'h07);
        vecs[28] = mk(1, 0, 1, 1,  1, 0, 0, 2'd0, 8'h00);
        // rstn pulse while 0x0F
        vecs[29] = mk(1, 1, 0, 4,  0, 0, 0, 2'd0, 8'h00);
        vecs[30] = mk(1, 1, 0, 17, 0, 0, 0, 2'd0, 8'h0F);
        vecs[31] = mk(0, 1, 0, 1,  1, 0, 0, 2'd0, 8'h00);
        vecs[32] = mk(1, 1, 0, 1,  1, 0, 0, 2'd0, 8'h00);

        for (int i = 0; i < NVEC; i++) begin
            for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].rstn, vecs[i].locked, vecs[i].sw);
            check($sformatf("vec%0d", i), {3'b0, dut_vec()},
                  {3'b0, vecs[i].pll_rst, vecs[i].pll_fail, vecs[i].all_ready,
                   vecs[i].retry, vecs[i].dom});
        end

        // Steady lock after reset: 29 edges from the reset edge to all_ready
        // (4 PLL reset + 1 lock seen + 8 stable + 8*2 stagger), one already spent in vec32.
        lat = 0;
        while (!bus.all_ready && lat < 200) begin
            tick(1'b1, 1'b1, 1'b0);
            lat++;
        end
        check("boot_latency", 16'(lat), 16'd28);

        // Random soak: lock held in long runs, sparse soft resets and hard resets.
        for (int seg = 0; seg < 150; seg++) begin
            l   = ($urandom_range(0, 9) < 7);
            len = l ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 80));
            for (int k = 0; k < len; k++) begin
                s = ($urandom_range(0, 29) == 0);
                r = ($urandom_range(0, 399) != 0);
                tick(r, l, s);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
